// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU load/store front end in front of a word-wide memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted
// and sign/zero-extended.
// Optional access-fault checking is enabled by defining MEM_ACCESS_FAULT_EN.
module mem_access_ctrl #(
  parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
  parameter logic [31:0] ROM_BASE  = 32'h0040_0000,
  parameter logic [31:0] WIN_BYTES = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  // Windows must be power-of-two sized and aligned to their size.
  if (((WIN_BYTES & (WIN_BYTES - 32'd1)) != 32'd0) ||
      ((RAM_BASE & (WIN_BYTES - 32'd1)) != 32'd0) ||
      ((ROM_BASE & (WIN_BYTES - 32'd1)) != 32'd0)) begin : g_bad_cfg
    $error("mem_access_ctrl: windows must be power-of-two sized and aligned");
  end

  state_t      state_q, state_d;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        fault;
  logic [1:0]  eff_size;
  logic [31:0] eff_addr;
  logic [4:0]  sh_amt;
  logic [31:0] rd_sh;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] load_ext;

  assign accept      = (state_q == IDLE) && req_valid_i;
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign mem_we_o    = (state_q == WR);

`ifdef MEM_ACCESS_FAULT_EN
  localparam logic [31:0] WIN_MASK = ~(WIN_BYTES - 32'd1);
  logic in_ram, in_rom, err_q;
  assign in_ram = (req_addr_i & WIN_MASK) == RAM_BASE;
  assign in_rom = (req_addr_i & WIN_MASK) == ROM_BASE;
  assign fault  = (req_size_i == 2'b11)
               || ((req_size_i == 2'b01) && req_addr_i[0])
               || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
               || !(in_ram || in_rom)
               || (req_we_i && in_rom);
  assign rsp_err_o = err_q;

  // Fault flag latched per request, held through RESP.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)    err_q <= 1'b0;
    else if (accept) err_q <= fault;
  end
`else
  assign fault     = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Size 11 behaves as a word; low address bits are masked to the size.
  // Faulting requests never reach memory, so masking is harmless there.
  always_comb begin
    eff_size = (req_size_i == 2'b11) ? 2'b10 : req_size_i;
    eff_addr = req_addr_i;
    case (eff_size)
      2'b01:   eff_addr = {req_addr_i[31:1], 1'b0};
      2'b10:   eff_addr = {req_addr_i[31:2], 2'b00};
      default: eff_addr = req_addr_i;
    endcase
  end

  // Lane extraction for loads and lane merge for read-modify-write stores.
  always_comb begin
    sh_amt    = {off_q, 3'b000};
    rd_sh     = mem_rdata_i >> sh_amt;
    lane_mask = '1;
    case (size_q)
      2'b00:   lane_mask = 32'h0000_00FF << sh_amt;
      2'b01:   lane_mask = 32'h0000_FFFF << sh_amt;
      default: lane_mask = '1;
    endcase
    merged   = (mem_rdata_i & ~lane_mask) | ((wdata_q << sh_amt) & lane_mask);
    load_ext = rd_sh;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, rd_sh[7:0]}  : {{24{rd_sh[7]}},  rd_sh[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: load_ext = rd_sh;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        if (fault)                              state_d = RESP;
        else if (req_we_i && eff_size == 2'b10) state_d = WR;
        else                                    state_d = RD;
      end
      RD:      state_d = WAIT;
      WAIT:    state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and memory/response data registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rsp_rdata_o <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          off_q       <= eff_addr[1:0];
          size_q      <= eff_size;
          uns_q       <= req_unsigned_i;
          we_q        <= req_we_i;
          wdata_q     <= req_wdata_i;
          rsp_rdata_o <= '0;
          if (!fault) begin
            mem_addr_o <= {eff_addr[31:2], 2'b00};
            if (req_we_i && eff_size == 2'b10) mem_wdata_o <= req_wdata_i;
          end
        end
        WAIT: begin
          if (we_q) mem_wdata_o <= merged;
          else      rsp_rdata_o <= load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule
